// File: rtl/sr_ff_pkg.sv
// Shared definitions for the sr_ff_bank set/reset flip-flop bank:
// forbidden-input resolution modes, per-channel next-state and popcount helpers.
package sr_ff_pkg;

    typedef enum logic [1:0] {
        MODE_RST_DOM = 2'd0,
        MODE_SET_DOM = 2'd1,
        MODE_HOLD    = 2'd2,
        MODE_TOGGLE  = 2'd3
    } sr_mode_e;

    localparam int MAX_N = 32;
    localparam int PC_MAX_W = 6;

    // Unknown mode values resolve like reset-dominant.
    function automatic logic sr_next(input int mode, input logic q, input logic s, input logic r);
        logic nq;
        nq = q;
        case ({s, r})
            2'b10: nq = 1'b1;
            2'b01: nq = 1'b0;
            2'b11: begin
                if (mode == int'(MODE_SET_DOM)) begin
                    nq = 1'b1;
                end else if (mode == int'(MODE_HOLD)) begin
                    nq = q;
                end else if (mode == int'(MODE_TOGGLE)) begin
                    nq = ~q;
                end else begin
                    nq = 1'b0;
                end
            end
            default: nq = q;
        endcase
        return nq;
    endfunction

    function automatic logic [PC_MAX_W-1:0] popcount32(input logic [MAX_N-1:0] v);
        logic [PC_MAX_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < MAX_N; i++) begin
            cnt = cnt + PC_MAX_W'(v[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/sr_ff_cell.sv
// One channel of sr_ff_bank: registered q/qb with selectable S=R=1 resolution
// and a sticky illegal-input flag.
module sr_ff_cell
    import sr_ff_pkg::*;
#(
    parameter int MODE = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic s,
    input  logic r,
    input  logic clr_illegal,
    output logic q,
    output logic qb,
    output logic illegal
);

    logic q_d, q_q;
    logic qb_d, qb_q;
    logic illegal_d, illegal_q;
    logic both;

    always_comb begin
        both = en & s & r;
        q_d  = q_q;
        if (en) begin
            q_d = sr_next(MODE, q_q, s, r);
        end
        qb_d = ~q_d;
        // A clear still captures an event arriving in the same cycle.
        if (clr_illegal) begin
            illegal_d = both;
        end else begin
            illegal_d = illegal_q | both;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q       <= 1'b0;
            qb_q      <= 1'b1;
            illegal_q <= 1'b0;
        end else begin
            q_q       <= q_d;
            qb_q      <= qb_d;
            illegal_q <= illegal_d;
        end
    end

    assign q       = q_q;
    assign qb      = qb_q;
    assign illegal = illegal_q;

endmodule

// File: rtl/sr_ff_bank.sv
// Bank of N synchronous set/reset flip-flops with sticky illegal flags and a
// saturating illegal-event counter. Define SR_FF_BANK_SYNC_IN_EN to add 2-flop
// input synchronisers on s, r and en.
module sr_ff_bank
    import sr_ff_pkg::*;
#(
    parameter int N     = 8,
    parameter int MODE  = 0,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N-1:0]     s,
    input  logic [N-1:0]     r,
    input  logic             clr_illegal,
    output logic [N-1:0]     q,
    output logic [N-1:0]     qb,
    output logic [N-1:0]     illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam int PC_W  = $clog2(N + 1);
    localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic         core_en;
    logic [N-1:0] core_s;
    logic [N-1:0] core_r;

`ifdef SR_FF_BANK_SYNC_IN_EN
    logic         en_p0_d, en_p0_q, en_p1_d, en_p1_q;
    logic [N-1:0] s_p0_d, s_p0_q, s_p1_d, s_p1_q;
    logic [N-1:0] r_p0_d, r_p0_q, r_p1_d, r_p1_q;

    always_comb begin
        en_p0_d = en;
        s_p0_d  = s;
        r_p0_d  = r;
        en_p1_d = en_p0_q;
        s_p1_d  = s_p0_q;
        r_p1_d  = r_p0_q;
    end

    // Synchroniser stages p0 -> p1; reset flushes anything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            en_p0_q <= 1'b0;
            s_p0_q  <= '0;
            r_p0_q  <= '0;
            en_p1_q <= 1'b0;
            s_p1_q  <= '0;
            r_p1_q  <= '0;
        end else begin
            en_p0_q <= en_p0_d;
            s_p0_q  <= s_p0_d;
            r_p0_q  <= r_p0_d;
            en_p1_q <= en_p1_d;
            s_p1_q  <= s_p1_d;
            r_p1_q  <= r_p1_d;
        end
    end

    assign core_en = en_p1_q;
    assign core_s  = s_p1_q;
    assign core_r  = r_p1_q;
`else
    assign core_en = en;
    assign core_s  = s;
    assign core_r  = r;
`endif

    for (genvar i = 0; i < N; i++) begin : g_cell
        sr_ff_cell #(
            .MODE(MODE)
        ) u_cell (
            .clk         (clk),
            .rst         (rst),
            .en          (core_en),
            .s           (core_s[i]),
            .r           (core_r[i]),
            .clr_illegal (clr_illegal),
            .q           (q[i]),
            .qb          (qb[i]),
            .illegal     (illegal[i])
        );
    end

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [PC_W-1:0] b);
        logic [SUM_W-1:0] sum;
        sum = SUM_W'(a) + SUM_W'(b);
        if (sum > SUM_W'(CNT_MAX)) begin
            return CNT_MAX;
        end
        return CNT_W'(sum);
    endfunction

    logic [PC_W-1:0]  events;
    logic [CNT_W-1:0] cnt_d, cnt_q;

    always_comb begin
        events = '0;
        if (core_en) begin
            events = PC_W'(popcount32(MAX_N'(core_s & core_r)));
        end
        if (clr_illegal) begin
            cnt_d = sat_add('0, events);
        end else begin
            cnt_d = sat_add(cnt_q, events);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_sr_ff_bank.sv
// Testbench for sr_ff_bank: four MODE variants with CNT_W=4 plus a default
// instance, checked every cycle against a vector-level model and literal values.
module tb_sr_ff_bank;

`ifdef SR_FF_BANK_SYNC_IN_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif
    localparam int NI = 5;

    logic       clk = 1'b0;
    logic       rst, en, clr;
    logic [7:0] s, r;

    logic [7:0]  q_w   [NI];
    logic [7:0]  qb_w  [NI];
    logic [7:0]  ill_w [NI];
    logic [15:0] cnt_w [NI];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < NI; k++) begin : g_dut
        localparam int MD = (k < 4) ? k : 0;
        localparam int CW = (k < 4) ? 4 : 8;
        logic [CW-1:0] cnt_l;
        sr_ff_bank #(.N(8), .MODE(MD), .CNT_W(CW)) u_dut (
            .clk         (clk),
            .rst         (rst),
            .en          (en),
            .s           (s),
            .r           (r),
            .clr_illegal (clr),
            .q           (q_w[k]),
            .qb          (qb_w[k]),
            .illegal     (ill_w[k]),
            .illegal_cnt (cnt_l)
        );
        assign cnt_w[k] = 16'(cnt_l);
    end

    // Behavioural model, whole-vector arithmetic per instance.
    logic [7:0] mq   [NI];
    logic [7:0] mill [NI];
    int         mcnt [NI];
    logic       mvalid = 1'b0;
    logic       e1 = 1'b0, e2 = 1'b0;
    logic [7:0] s1 = '0, s2 = '0, r1 = '0, r2 = '0;

    task automatic cmp(input string name, input int k, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d t=%0t got=%h want=%h", name, k, $time, act, exp);
        end
    endtask

    always @(posedge clk) begin
        logic       ce;
        logic [7:0] cs, cr, both;
        int         pc, cmax, md;
        if (rst) begin
            for (int k = 0; k < NI; k++) begin
                mq[k] = '0; mill[k] = '0; mcnt[k] = 0;
            end
            e1 = 0; e2 = 0; s1 = '0; s2 = '0; r1 = '0; r2 = '0;
            mvalid = 1'b1;
        end else begin
`ifdef SR_FF_BANK_SYNC_IN_EN
            ce = e2; cs = s2; cr = r2;
            e2 = e1; s2 = s1; r2 = r1;
            e1 = en; s1 = s;  r1 = r;
`else
            ce = en; cs = s; cr = r;
`endif
            both = cs & cr;
            pc   = ce ? $countones(both) : 0;
            for (int k = 0; k < NI; k++) begin
                md   = (k < 4) ? k : 0;
                cmax = (k < 4) ? 15 : 255;
                if (ce) begin
                    mq[k] = (mq[k] | (cs & ~cr)) & ~(cr & ~cs);
                    if (md == 0) mq[k] = mq[k] & ~both;
                    else if (md == 1) mq[k] = mq[k] | both;
                    else if (md == 3) mq[k] = mq[k] ^ both;
                end
                if (clr) begin
                    mill[k] = ce ? both : 8'h00;
                    mcnt[k] = (pc > cmax) ? cmax : pc;
                end else begin
                    if (ce) mill[k] = mill[k] | both;
                    mcnt[k] = (mcnt[k] + pc > cmax) ? cmax : mcnt[k] + pc;
                end
            end
        end
        #1;
        if (mvalid) begin
            for (int k = 0; k < NI; k++) begin
                cmp("q", k, {8'h00, q_w[k]}, {8'h00, mq[k]});
                cmp("qb", k, {8'h00, qb_w[k]}, {8'h00, ~mq[k]});
                cmp("illegal", k, {8'h00, ill_w[k]}, {8'h00, mill[k]});
                cmp("cnt", k, cnt_w[k], 16'(mcnt[k]));
            end
        end
    end

    task automatic cyc(input logic en_i, input logic [7:0] s_i, input logic [7:0] r_i,
                       input logic clr_i, input logic rst_i);
        @(negedge clk);
        en = en_i; s = s_i; r = r_i; clr = clr_i; rst = rst_i;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 8'h00, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic lit(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL lit_%s t=%0t got=%h want=%h", name, $time, act, exp);
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; s = 8'hFF; r = 8'h00; clr = 1'b0;
        cyc(1'b1, 8'hFF, 8'h00, 1'b0, 1'b1);
        cyc(1'b1, 8'hFF, 8'h00, 1'b0, 1'b1);
        idle(LAT);
        lit("rst_q", {8'h00, q_w[0]}, 16'h0000);
        lit("rst_qb", {8'h00, qb_w[0]}, 16'h00FF);
        lit("rst_ill", {8'h00, ill_w[0]}, 16'h0000);
        lit("rst_cnt", cnt_w[0], 16'h0000);

        cyc(1'b1, 8'h05, 8'h00, 1'b0, 1'b0);
        idle(LAT);
        lit("set_q", {8'h00, q_w[0]}, 16'h0005);
        idle(2);
        lit("hold_q", {8'h00, q_w[0]}, 16'h0005);
        cyc(1'b1, 8'h00, 8'h01, 1'b0, 1'b0);
        idle(LAT);
        lit("reset_q", {8'h00, q_w[0]}, 16'h0004);
        lit("reset_qb", {8'h00, qb_w[0]}, 16'h00FB);

        cyc(1'b1, 8'h00, 8'hFF, 1'b0, 1'b0);
        cyc(1'b1, 8'h0F, 8'h00, 1'b0, 1'b0);
        idle(LAT);
        cyc(1'b1, 8'h33, 8'h33, 1'b0, 1'b0);
        idle(LAT);
        lit("mode0_q", {8'h00, q_w[0]}, 16'h000C);
        lit("mode1_q", {8'h00, q_w[1]}, 16'h003F);
        lit("mode2_q", {8'h00, q_w[2]}, 16'h000F);
        lit("mode3_q", {8'h00, q_w[3]}, 16'h003C);
        lit("mode_ill", {8'h00, ill_w[2]}, 16'h0033);
        lit("mode_cnt", cnt_w[3], 16'h0004);

        for (int i = 0; i < 5; i++) cyc(1'b0, 8'hFF, 8'hFF, 1'b0, 1'b0);
        idle(LAT);
        lit("gate_q", {8'h00, q_w[3]}, 16'h003C);
        lit("gate_ill", {8'h00, ill_w[0]}, 16'h0033);
        lit("gate_cnt", cnt_w[0], 16'h0004);

        cyc(1'b1, 8'h00, 8'h00, 1'b1, 1'b0);
        idle(LAT);
        lit("clr_cnt", cnt_w[0], 16'h0000);
        lit("clr_ill", {8'h00, ill_w[0]}, 16'h0000);
        for (int i = 0; i < 3; i++) cyc(1'b1, 8'hFF, 8'hFF, 1'b0, 1'b0);
        idle(LAT);
        lit("sat_cnt4", cnt_w[0], 16'h000F);
        lit("sat_cnt8", cnt_w[4], 16'h0018);
        for (int i = 0; i < LAT; i++) cyc(1'b1, 8'h01, 8'h01, (i == LAT - 1), 1'b0);
        idle(1);
        lit("coll_ill", {8'h00, ill_w[0]}, 16'h0001);
        lit("coll_cnt", cnt_w[0], 16'h0001);
        lit("coll_cnt8", cnt_w[4], 16'h0001);
        idle(LAT);

        cyc(1'b1, 8'h00, 8'hFF, 1'b0, 1'b0);
        idle(LAT);
        cyc(1'b1, 8'h80, 8'h00, 1'b0, 1'b0);
        for (int k = 1; k <= LAT; k++) begin
            idle(1);
            lit("pulse_q7", {15'd0, q_w[0][7]}, (k == LAT) ? 16'h0001 : 16'h0000);
        end
        cyc(1'b1, 8'h80, 8'h00, 1'b0, 1'b0);
        cyc(1'b1, 8'h00, 8'h00, 1'b0, 1'b1);
        idle(LAT + 1);
        lit("rst_flush_q", {8'h00, q_w[0]}, 16'h0000);
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sr_ff_bank.md
Name: sr_ff_bank

Overview:
- Parametrised, clocked successor to the single NOR RS latch: a bank of N independent synchronous set/reset flip-flops.
- Selectable resolution of the forbidden S=R=1 input.
- Per-channel sticky illegal-input flags and a saturating illegal-event counter.
- Used wherever the design needs many registered status/flag bits with explicit set/clear strobes.

Parameters:
- N, 8, number of channels (1..32).
- MODE, 0, S=R=1 resolution: 0=reset-dominant, 1=set-dominant, 2=hold, 3=toggle.
- CNT_W, 8, width of the illegal-event counter (2..16).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  global enable; low means the bank ignores s/r.
- s  input  N  per-channel set strobe.
- r  input  N  per-channel reset strobe.
- clr_illegal  input  1  clears illegal flags and counter.
- q  output  N  channel state.
- qb  output  N  complement of q.
- illegal  output  N  sticky per-channel flag, set on S=R=1 while enabled.
- illegal_cnt  output  CNT_W  saturating count of illegal channel-events.

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clk, rst).
- Reset: rst=1 at a rising edge sets q=0, qb=all ones, illegal=0, illegal_cnt=0.
  - rst overrides en, s, r and clr_illegal in the same cycle.
  - Reset mid-operation discards all state, including pending synchronised inputs (see optional feature).
- All outputs are registered. q and qb update one cycle after the s/r sample.
- qb is always ~q. The NOR-latch q=qb=0 condition cannot occur.
- Per-channel next state when en=1:
  - s=0, r=0: hold.
  - s=1, r=0: q=1.
  - s=0, r=1: q=0.
  - s=1, r=1: per MODE. 0: q=0. 1: q=1. 2: hold. 3: q=~q.
- en=0: every q holds. No illegal detection and no counter update.
- Illegal event: en=1 and s[i]=r[i]=1. It sets illegal[i]=1, which stays set until clr_illegal or rst.
- illegal_cnt adds popcount(s & r) on each enabled cycle and saturates at 2^CNT_W-1. No wrap.
- clr_illegal=1 at an edge:
  - illegal = the current cycle's (s & r) if en=1, otherwise 0.
  - illegal_cnt = popcount(s & r) if en=1, otherwise 0.
  - Events in the clearing cycle are never lost.
- The adder width must hold popcount of N (clog2(N+1) bits) before the saturating add to CNT_W.
- MODE values outside 0..3 fall back to reset-dominant behaviour.

Optional Feature:
- Macro: SR_FF_BANK_SYNC_IN_EN.
- Defined:
  - s, r and en each pass through a 2-flop synchroniser before the core logic.
  - q/qb/illegal latency becomes 3 cycles from input change.
  - rst clears the synchroniser flops to 0.
  - clr_illegal stays unsynchronised and combines with the synchronised s/r of that cycle.
- Not defined: inputs feed the core directly, 1-cycle latency, no extra flops.

Decomposition:
- Package sr_ff_pkg holds:
  - MODE encodings: MODE_RST_DOM=0, MODE_SET_DOM=1, MODE_HOLD=2, MODE_TOGGLE=3.
  - A function for the per-channel next state.
  - A popcount function.
- Sub-module sr_ff_cell holds one channel (q register + next-state logic + illegal detect). It is instantiated N times via generate.
- The counter, clear logic and optional synchroniser live in the top level.

Test Plan:
- Reset: rst=1 with s=8'hFF, r=8'h00, en=1 -> next cycle q=8'h00, qb=8'hFF, illegal=0, illegal_cnt=0.
- Set/hold/reset: from q=0, s=8'h05 for 1 cycle, then s=r=0 for 2 cycles, then r=8'h01 -> q=8'h05, holds 8'h05, then q=8'h04; qb=~q on every cycle.
- Modes (N=8, run each MODE): q=8'h0F, then s=r=8'h33 for 1 cycle:
  - MODE0 -> q=8'h0C.
  - MODE1 -> q=8'h3F.
  - MODE2 -> q=8'h0F.
  - MODE3 -> q=8'h3C.
  - All modes: illegal=8'h33, illegal_cnt=4.
- Enable gating: en=0 with s=8'hFF, r=8'hFF for 5 cycles -> q unchanged, illegal unchanged, illegal_cnt unchanged.
- Saturation and clear collision (CNT_W=4): s=r=8'hFF for 3 cycles -> cnt=8, 15, 15. Then clr_illegal=1 with s=r=8'h01 -> illegal=8'h01, illegal_cnt=1.
- Synchroniser build (SR_FF_BANK_SYNC_IN_EN): s=8'h80 pulse at cycle 0 -> q[7] rises at cycle 3.
  - rst asserted at cycle 1 -> q stays 0 and the synchronisers are flushed.
